adc_avg_minmax: RTL and testbench
=================================

Name: adc_avg_minmax

Overview:
- Sits directly downstream of max1112x_reader in the EMI test top. Consumes its dv strobe and the packed 4-channel sample word.
- For each channel, over a window of 2^C_avg_log2 samples, produces the windowed average, minimum and maximum.
- Results are registered and flagged with a 1-cycle out_valid pulse, so vgaout can show stable per-channel readings instead of raw jittering samples.
- Runs in the ADC clock domain (clk_pixel in the top).

Parameters:
- C_channels, 4, number of packed channels.
- C_bits, 12, unsigned sample width per channel.
- C_avg_log2, 4, log2 of the window length (16 samples). Legal range 0..8.

Ports:
- clk  input  1  ADC domain clock.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- clken  input  1  when low, dv and clear are ignored and all state is held.
- clear  input  1  restarts the current window; outputs are unaffected.
- dv  input  1  1-cycle sample strobe from the reader.
- data  input  C_channels*C_bits  packed samples. Channel k is at [k*C_bits +: C_bits], so ch0 is in [C_bits-1:0].
- avg  output  C_channels*C_bits  windowed averages, same packing as data.
- min  output  C_channels*C_bits  windowed minima.
- max  output  C_channels*C_bits  windowed maxima.
- out_valid  output  1  1-cycle pulse when avg/min/max update.
- window_count  output  16  number of completed windows; wraps 0xFFFF -> 0.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - accumulators = 0, sample counter = 0.
  - running min = all ones per channel, running max = 0.
  - outputs: avg = 0, min = 0, max = 0, out_valid = 0, window_count = 0.
  - A reset mid-window discards the partial window.
- Accumulator:
  - One per channel, width C_bits+C_avg_log2, so it never overflows.
  - Samples are unsigned.
- Accept cycle (clken=1, dv=1, clear=0), per channel k:
  - acc += s_k.
  - running min = min(running min, s_k); running max = max(running max, s_k).
  - Sample counter increments.
- Completing sample (counter = 2^C_avg_log2 - 1 on an accept cycle). At the same edge:
  - avg_k <= (acc + s_k) >> C_avg_log2, i.e. truncating divide with the completing sample included.
  - min_k and max_k <= running values including s_k.
  - out_valid <= 1; window_count <= window_count + 1.
  - acc <= 0, counter <= 0, running min <= all ones, running max <= 0.
- Latency: outputs and out_valid are visible on the cycle after the completing dv.
  - out_valid is high for exactly 1 cycle; otherwise 0.
  - Outputs hold between windows.
- Back-to-back: a dv on the cycle right after a completing dv is the first sample of the next window. No sample is lost.
- C_avg_log2 = 0: every accepted dv completes a window; avg = min = max = sample, 1 cycle later.
- clear=1 with clken=1:
  - Window restarts; avg/min/max/out_valid/window_count are untouched.
  - If dv=1 in the same cycle, clear wins over accumulation. That sample becomes sample 1 of the new window: acc = s, counter = 1, min = max = s.
  - Exception when C_avg_log2 = 0: that sample completes immediately, exactly as in the completing-sample case.
  - clear never produces out_valid, except in the C_avg_log2 = 0 case above.
- clken=0: dv and clear are ignored and no state changes. out_valid is 0 on the following cycle.
- Only dv is sampled; data is don't-care when dv=0.
- No combinational path from inputs to outputs; every output is a register.

Test Plan:
- Reset then 16 dv (one every 4 cycles), ch0=0x100..0x10F, ch1..3=0xABC -> single out_valid 1 cycle after 16th dv.
  - ch0: avg=0x107, min=0x100, max=0x10F.
  - ch1..3: avg=min=max=0xABC.
  - window_count=1.
- 32 dv on consecutive cycles, ch0 = 0xFFF then 0x000 alternating -> two out_valid pulses 16 cycles apart, each with avg=0x7FF, min=0x000, max=0xFFF. No sample dropped; window_count=2.
- Feed 10 samples of 0xFFF, assert clear together with a dv of 0x010, then 15 dv of 0x010 -> out_valid after the 15th; ch0 avg=min=max=0x010. Outputs unchanged at the clear cycle.
- Feed 8 samples, drop clken for 50 cycles while toggling dv and clear, restore, feed 8 samples -> exactly one out_valid, after the 16th accepted sample. avg matches only the accepted samples.
- rst_n low for 1 cycle after 12 samples -> all outputs 0. The next window needs a full 16 samples before out_valid.
- C_avg_log2=0 build, dv with ch2=0x5A5 -> next cycle out_valid=1 and ch2 avg=min=max=0x5A5. Force window_count to 0xFFFF first; it wraps to 0.

Source files
------------

// File: rtl/adc_avg_minmax.sv
// Per-channel windowed average, minimum and maximum over 2^C_avg_log2 accepted samples.
// All outputs are registered; out_valid pulses for one cycle when a window completes.
module adc_avg_minmax #(
    parameter int C_channels = 4,
    parameter int C_bits     = 12,
    parameter int C_avg_log2 = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clken,
    input  logic                           clear,
    input  logic                           dv,
    input  logic [C_channels*C_bits-1:0]   data,
    output logic [C_channels*C_bits-1:0]   avg,
    output logic [C_channels*C_bits-1:0]   min,
    output logic [C_channels*C_bits-1:0]   max,
    output logic                           out_valid,
    output logic [15:0]                    window_count
);

    localparam int ACC_W = C_bits + C_avg_log2;
    localparam int CNT_W = (C_avg_log2 > 0) ? C_avg_log2 : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << C_avg_log2) - 1);
    localparam int W = C_channels * C_bits;

    logic [ACC_W-1:0]  acc_q  [C_channels];
    logic [ACC_W-1:0]  acc_d  [C_channels];
    logic [C_bits-1:0] rmin_q [C_channels];
    logic [C_bits-1:0] rmin_d [C_channels];
    logic [C_bits-1:0] rmax_q [C_channels];
    logic [C_bits-1:0] rmax_d [C_channels];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]      avg_q, avg_d, min_q, min_d, max_q, max_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       window_count_q, window_count_d;

    logic [C_bits-1:0] smp_s   [C_channels];
    logic [ACC_W-1:0]  sum_s   [C_channels];
    logic [C_bits-1:0] nmin_s  [C_channels];
    logic [C_bits-1:0] nmax_s  [C_channels];
    logic [CNT_W-1:0]  cnt_base_s;

    // Candidate window state including the incoming sample; clear drops the running window first.
    always_comb begin
        for (int k = 0; k < C_channels; k++) begin
            smp_s[k] = data[k*C_bits +: C_bits];
            if (clear) begin
                sum_s[k]  = ACC_W'(smp_s[k]);
                nmin_s[k] = smp_s[k];
                nmax_s[k] = smp_s[k];
            end else begin
                sum_s[k]  = acc_q[k] + ACC_W'(smp_s[k]);
                nmin_s[k] = (smp_s[k] < rmin_q[k]) ? smp_s[k] : rmin_q[k];
                nmax_s[k] = (smp_s[k] > rmax_q[k]) ? smp_s[k] : rmax_q[k];
            end
        end
        cnt_base_s = clear ? {CNT_W{1'b0}} : cnt_q;
    end

    // Next-state: accept, complete a window, restart on clear, or hold.
    always_comb begin
        acc_d          = acc_q;
        rmin_d         = rmin_q;
        rmax_d         = rmax_q;
        cnt_d          = cnt_q;
        avg_d          = avg_q;
        min_d          = min_q;
        max_d          = max_q;
        window_count_d = window_count_q;
        out_valid_d    = 1'b0;
        if (clken && dv) begin
            if (cnt_base_s == LAST) begin
                for (int k = 0; k < C_channels; k++) begin
                    avg_d[k*C_bits +: C_bits] = C_bits'(sum_s[k] >> C_avg_log2);
                    min_d[k*C_bits +: C_bits] = nmin_s[k];
                    max_d[k*C_bits +: C_bits] = nmax_s[k];
                    acc_d[k]  = {ACC_W{1'b0}};
                    rmin_d[k] = {C_bits{1'b1}};
                    rmax_d[k] = {C_bits{1'b0}};
                end
                cnt_d          = {CNT_W{1'b0}};
                out_valid_d    = 1'b1;
                window_count_d = window_count_q + 16'd1;
            end else begin
                for (int k = 0; k < C_channels; k++) begin
                    acc_d[k]  = sum_s[k];
                    rmin_d[k] = nmin_s[k];
                    rmax_d[k] = nmax_s[k];
                end
                cnt_d = cnt_base_s + CNT_W'(1);
            end
        end else if (clken && clear) begin
            for (int k = 0; k < C_channels; k++) begin
                acc_d[k]  = {ACC_W{1'b0}};
                rmin_d[k] = {C_bits{1'b1}};
                rmax_d[k] = {C_bits{1'b0}};
            end
            cnt_d = {CNT_W{1'b0}};
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < C_channels; k++) begin
                acc_q[k]  <= {ACC_W{1'b0}};
                rmin_q[k] <= {C_bits{1'b1}};
                rmax_q[k] <= {C_bits{1'b0}};
            end
            cnt_q          <= {CNT_W{1'b0}};
            avg_q          <= {W{1'b0}};
            min_q          <= {W{1'b0}};
            max_q          <= {W{1'b0}};
            out_valid_q    <= 1'b0;
            window_count_q <= 16'd0;
        end else begin
            acc_q          <= acc_d;
            rmin_q         <= rmin_d;
            rmax_q         <= rmax_d;
            cnt_q          <= cnt_d;
            avg_q          <= avg_d;
            min_q          <= min_d;
            max_q          <= max_d;
            out_valid_q    <= out_valid_d;
            window_count_q <= window_count_d;
        end
    end

    assign avg          = avg_q;
    assign min          = min_q;
    assign max          = max_q;
    assign out_valid    = out_valid_q;
    assign window_count = window_count_q;

endmodule

// File: tb/tb_adc_avg_minmax.sv
// Self-checking bench: a 16-sample build checked against a window-queue model, and a
// single-sample build exercised from a vector table including the window_count wrap.
module tb_adc_avg_minmax;

    localparam int NCH  = 4;
    localparam int BITS = 12;
    localparam int L    = 4;
    localparam int N    = 1 << L;
    localparam int W    = NCH * BITS;

    logic         clk;
    logic         rst_n, clken, clear, dv;
    logic [W-1:0] data, avg_o, min_o, max_o;
    logic         ov_o;
    logic [15:0]  wc_o;

    logic         rst0_n, clken0, clear0, dv0;
    logic [W-1:0] data0, avg0, min0, max0;
    logic         ov0;
    logic [15:0]  wc0;

    int checks = 0;
    int errors = 0;
    int cycle_no = 0;
    int pulses = 0;
    int last_pulse = 0;

    logic [W-1:0] win[$];
    logic [W-1:0] e_avg, e_min, e_max;
    logic         e_ov;
    logic [15:0]  e_wc;

    typedef struct {
        logic         ce;
        logic         clr;
        logic         v;
        logic [W-1:0] d;
        logic         ov;
        logic [W-1:0] e;
        logic [15:0]  wc;
    } vec_t;
    vec_t tbl[6];

    adc_avg_minmax #(.C_channels(NCH), .C_bits(BITS), .C_avg_log2(L)) dut (
        .clk(clk), .rst_n(rst_n), .clken(clken), .clear(clear), .dv(dv), .data(data),
        .avg(avg_o), .min(min_o), .max(max_o), .out_valid(ov_o), .window_count(wc_o));

    adc_avg_minmax #(.C_channels(NCH), .C_bits(BITS), .C_avg_log2(0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .clken(clken0), .clear(clear0), .dv(dv0), .data(data0),
        .avg(avg0), .min(min0), .max(max0), .out_valid(ov0), .window_count(wc0));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cycle_no, act, exp);
        end
    endtask

    // Reference: collect accepted samples of the current window, reduce when it is full.
    task automatic model_step(input logic r, input logic ce, input logic clr, input logic v,
                              input logic [W-1:0] d);
        logic [W-1:0]    w;
        int unsigned     sum, mn, mx, s;
        e_ov = 1'b0;
        if (!r) begin
            win.delete();
            e_avg = '0; e_min = '0; e_max = '0; e_wc = 16'd0;
        end else if (ce) begin
            if (clr) win.delete();
            if (v) begin
                win.push_back(d);
                if (win.size() == N) begin
                    for (int c = 0; c < NCH; c++) begin
                        sum = 0; mn = 4095; mx = 0;
                        for (int i = 0; i < N; i++) begin
                            w = win[i];
                            s = int'(w[c*BITS +: BITS]);
                            sum += s;
                            if (s < mn) mn = s;
                            if (s > mx) mx = s;
                        end
                        e_avg[c*BITS +: BITS] = BITS'(sum / N);
                        e_min[c*BITS +: BITS] = BITS'(mn);
                        e_max[c*BITS +: BITS] = BITS'(mx);
                    end
                    e_ov = 1'b1;
                    e_wc = e_wc + 16'd1;
                    win.delete();
                end
            end
        end
    endtask

    task automatic cyc(input logic ce, input logic clr, input logic v, input logic [W-1:0] d);
        clken = ce; clear = clr; dv = v; data = d;
        model_step(rst_n, ce, clr, v, d);
        @(posedge clk); #1;
        cycle_no++;
        chk("model_avg", avg_o, e_avg);
        chk("model_min", min_o, e_min);
        chk("model_max", max_o, e_max);
        chk("model_out_valid", W'(ov_o), W'(e_ov));
        chk("model_window_count", W'(wc_o), W'(e_wc));
        if (ov_o) begin
            pulses++;
            last_pulse = cycle_no;
        end
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 1'b0, {16'($urandom), 32'($urandom)});
    endtask

    function automatic logic [W-1:0] rnd();
        return {16'($urandom), 32'($urandom)};
    endfunction

    initial begin
        logic [W-1:0] sa, smi, sma;
        logic [15:0]  wbase;
        int           p0, first_pulse;

        tbl[0] = '{1'b1, 1'b0, 1'b1, 48'h000_5A5_000_000, 1'b1, 48'h000_5A5_000_000, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 48'hFFF_FFF_FFF_FFF, 1'b0, 48'h000_5A5_000_000, 16'h0000};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 48'h123_456_789_ABC, 1'b0, 48'h000_5A5_000_000, 16'h0000};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 48'hFFF_001_800_7FF, 1'b1, 48'hFFF_001_800_7FF, 16'h0001};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 48'h123_456_789_ABC, 1'b0, 48'hFFF_001_800_7FF, 16'h0001};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 48'h0AB_CDE_F01_234, 1'b1, 48'h0AB_CDE_F01_234, 16'h0002};

        rst0_n = 1'b0; clken0 = 1'b0; clear0 = 1'b0; dv0 = 1'b0; data0 = '0;

        // Reset values
        rst_n = 1'b0;
        cyc(1'b1, 1'b0, 1'b1, rnd());
        rst_n = 1'b1;
        chk("reset_avg", avg_o, '0);
        chk("reset_min", min_o, '0);
        chk("reset_max", max_o, '0);
        chk("reset_valid", W'(ov_o), '0);
        chk("reset_wc", W'(wc_o), '0);

        // Ramp window, one dv every 4 cycles
        for (int i = 0; i < N; i++) begin
            cyc(1'b1, 1'b0, 1'b1, {12'hABC, 12'hABC, 12'hABC, 12'h100 + 12'(i)});
            if (i < N - 1) repeat (3) idle();
        end
        chk("ramp_valid", W'(ov_o), W'(1'b1));
        chk("ramp_avg", avg_o, 48'hABC_ABC_ABC_107);
        chk("ramp_min", min_o, 48'hABC_ABC_ABC_100);
        chk("ramp_max", max_o, 48'hABC_ABC_ABC_10F);
        chk("ramp_wc", W'(wc_o), W'(16'd1));
        idle();
        chk("ramp_valid_pulse_width", W'(ov_o), '0);

        // Back-to-back alternating extremes
        wbase = wc_o; p0 = pulses; first_pulse = 0;
        for (int i = 0; i < 2 * N; i++) begin
            cyc(1'b1, 1'b0, 1'b1, {36'h0, (i % 2 == 0) ? 12'hFFF : 12'h000});
            if (ov_o) begin
                if (first_pulse == 0) first_pulse = cycle_no;
                chk("alt_avg", avg_o, 48'h000_000_000_7FF);
                chk("alt_min", min_o, 48'h000_000_000_000);
                chk("alt_max", max_o, 48'h000_000_000_FFF);
            end
        end
        chk("alt_pulses", W'(pulses - p0), W'(2));
        chk("alt_gap", W'(last_pulse - first_pulse), W'(N));
        chk("alt_wc", W'(wc_o), W'(wbase + 16'd2));

        // Clear together with a dv restarts the window
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1, {4{12'hFFF}});
        sa = avg_o; smi = min_o; sma = max_o; wbase = wc_o;
        cyc(1'b1, 1'b1, 1'b1, {4{12'h010}});
        chk("clear_valid", W'(ov_o), '0);
        chk("clear_avg_hold", avg_o, sa);
        chk("clear_min_hold", min_o, smi);
        chk("clear_max_hold", max_o, sma);
        chk("clear_wc_hold", W'(wc_o), W'(wbase));
        for (int i = 0; i < N - 1; i++) begin
            cyc(1'b1, 1'b0, 1'b1, {4{12'h010}});
            if (i == N - 3) chk("clear_no_early_valid", W'(ov_o), '0);
        end
        chk("clear_done_valid", W'(ov_o), W'(1'b1));
        chk("clear_avg", avg_o, {4{12'h010}});
        chk("clear_min", min_o, {4{12'h010}});
        chk("clear_max", max_o, {4{12'h010}});

        // clken low freezes everything
        p0 = pulses;
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1, rnd());
        for (int i = 0; i < 50; i++) cyc(1'b0, 1'($urandom), 1'($urandom), rnd());
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1, rnd());
        chk("clken_pulses", W'(pulses - p0), W'(1));
        chk("clken_valid_last", W'(ov_o), W'(1'b1));

        // Reset mid-window discards the partial window
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b1, rnd());
        rst_n = 1'b0;
        cyc(1'b1, 1'b0, 1'b1, rnd());
        rst_n = 1'b1;
        chk("midreset_avg", avg_o, '0);
        chk("midreset_min", min_o, '0);
        chk("midreset_max", max_o, '0);
        chk("midreset_wc", W'(wc_o), '0);
        p0 = pulses;
        for (int i = 0; i < N - 1; i++) cyc(1'b1, 1'b0, 1'b1, rnd());
        chk("midreset_no_early", W'(pulses - p0), '0);
        cyc(1'b1, 1'b0, 1'b1, rnd());
        chk("midreset_full_window", W'(ov_o), W'(1'b1));

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0),
                1'($urandom), rnd());
        end

        // Single-sample build: run window_count up to 0xFFFF, then the vector table
        clken = 1'b0; dv = 1'b0; clear = 1'b0;
        @(posedge clk); #1;
        rst0_n = 1'b1; clken0 = 1'b1; dv0 = 1'b1; data0 = 48'h111_222_333_444;
        repeat (65535) @(posedge clk);
        #1;
        chk("l0_wc_saturate", W'(wc0), W'(16'hFFFF));
        chk("l0_avg_prefill", avg0, 48'h111_222_333_444);
        for (int i = 0; i < 6; i++) begin
            clken0 = tbl[i].ce; clear0 = tbl[i].clr; dv0 = tbl[i].v; data0 = tbl[i].d;
            @(posedge clk); #1;
            chk($sformatf("l0_vec%0d_valid", i), W'(ov0), W'(tbl[i].ov));
            chk($sformatf("l0_vec%0d_avg", i), avg0, tbl[i].e);
            chk($sformatf("l0_vec%0d_min", i), min0, tbl[i].e);
            chk($sformatf("l0_vec%0d_max", i), max0, tbl[i].e);
            chk($sformatf("l0_vec%0d_wc", i), W'(wc0), W'(tbl[i].wc));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
